mic_frame_aligner: RTL and testbench

- Sits directly downstream of the three I2S mic receivers, in the audio_clk domain.
- Each mic delivers a 16-bit sample with a one-cycle valid strobe; the strobes are not mutually aligned.
- The block gathers one sample per mic into a coherent 3-channel frame and buffers frames in a small FIFO.
- Frames go out on a valid/ready interface to the delay/correlation stages.

---
 rtl/mic_frame_aligner.sv | 190 +++++++++++++++++++
 tb/tb_mic_frame_aligner.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_frame_aligner.sv
// mic_frame_aligner: gathers one sample per mic into a 3-channel frame and queues frames in a FWFT FIFO.
// Optional macro MIC_FRAME_ALIGNER_DC_BLOCK_EN inserts a per-channel DC blocker ahead of capture (+1 cycle).
module mic_frame_aligner #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                   audio_clk,
    input  logic                   rst_in,
    input  logic [2:0]             valid_in,
    input  logic [WIDTH-1:0]       sample_1_in,
    input  logic [WIDTH-1:0]       sample_2_in,
    input  logic [WIDTH-1:0]       sample_3_in,
    input  logic                   frame_ready_in,
    output logic                   frame_valid_out,
    output logic [3*WIDTH-1:0]     frame_out,
    output logic [$clog2(DEPTH):0] fill_out,
    output logic                   overflow_out,
    output logic [7:0]             drop_count_out,
    output logic                   timeout_out
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FW  = AW + 1;
    localparam int CW  = $clog2(TIMEOUT);
    localparam int FRW = 3 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUSH} state_t;

    logic [2:0]       w_valid;
    logic [WIDTH-1:0] w_smp [3];

`ifdef MIC_FRAME_ALIGNER_DC_BLOCK_EN
    localparam int ACCW = WIDTH + 8;
    localparam int DIFW = WIDTH + 9;

    logic signed [ACCW-1:0] r_acc [3];
    logic [WIDTH-1:0]       r_y [3];
    logic [2:0]             r_vld_d;
    logic [WIDTH-1:0]       w_raw [3];
    logic signed [DIFW-1:0] w_diff [3];
    logic signed [DIFW-1:0] w_step [3];
    logic [WIDTH-1:0]       w_y [3];

    assign w_raw[0] = sample_1_in;
    assign w_raw[1] = sample_2_in;
    assign w_raw[2] = sample_3_in;

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            w_diff[i] = $signed({{9{w_raw[i][WIDTH-1]}}, w_raw[i]}) - $signed({r_acc[i][ACCW-1], r_acc[i]});
            w_step[i] = w_diff[i] >>> 8;
            // Saturate when the bits above the output sign are not a pure sign extension.
            if (w_diff[i][DIFW-1:WIDTH-1] == '0 || w_diff[i][DIFW-1:WIDTH-1] == '1)
                w_y[i] = w_diff[i][WIDTH-1:0];
            else if (w_diff[i][DIFW-1])
                w_y[i] = {1'b1, {(WIDTH-1){1'b0}}};
            else
                w_y[i] = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_vld_d <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_acc[i] <= '0;
                r_y[i]   <= '0;
            end
        end else begin
            r_vld_d <= valid_in;
            for (int unsigned i = 0; i < 3; i++) begin
                if (valid_in[i]) begin
                    r_acc[i] <= r_acc[i] + w_step[i][ACCW-1:0];
                    r_y[i]   <= w_y[i];
                end
            end
        end
    end

    assign w_valid  = r_vld_d;
    assign w_smp[0] = r_y[0];
    assign w_smp[1] = r_y[1];
    assign w_smp[2] = r_y[2];
`else
    assign w_valid  = valid_in;
    assign w_smp[0] = sample_1_in;
    assign w_smp[1] = sample_2_in;
    assign w_smp[2] = sample_3_in;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_have;
    logic [WIDTH-1:0] r_cap [3];
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_drop;
    logic             r_ovf;
    logic             r_timeout;
    logic [FRW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [FW-1:0]    r_fill;

    logic [2:0]       w_have_new;
    logic             w_tofire;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_push_ok;
    logic             w_ovf_drop;
    logic [2:0]       w_drop_inc;
    logic [8:0]       w_drop_sum;
    logic [FRW-1:0]   w_frame;

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Strobes seen during PUSH start the next frame, so the clear is applied before OR-ing them in.
    always_comb begin
        w_have_new = ((r_state == S_PUSH) ? 3'b000 : r_have) | w_valid;
        w_tofire   = (r_state == S_COLLECT) && (r_cnt == CW'(TIMEOUT - 2)) && (w_have_new != 3'b111);
        w_next     = S_IDLE;
        if (w_tofire)                  w_next = S_IDLE;
        else if (w_have_new == 3'b111) w_next = S_PUSH;
        else if (|w_have_new)          w_next = S_COLLECT;
    end

    always_comb begin
        w_push     = (r_state == S_PUSH);
        w_pop      = (r_fill != '0) && frame_ready_in;
        w_full     = (r_fill == FW'(DEPTH));
        w_push_ok  = w_push && (!w_full || w_pop);
        w_ovf_drop = w_push && w_full && !w_pop;
        w_drop_inc = 3'(w_ovf_drop);
        if (w_tofire)
            w_drop_inc = 3'd1 + 3'(w_valid[0]) + 3'(w_valid[1]) + 3'(w_valid[2]);
        else if (r_state != S_PUSH)
            w_drop_inc = 3'(w_ovf_drop) + 3'(w_valid[0] & r_have[0])
                       + 3'(w_valid[1] & r_have[1]) + 3'(w_valid[2] & r_have[2]);
        w_drop_sum = {1'b0, r_drop} + 9'(w_drop_inc);
        w_frame    = {r_cap[2], r_cap[1], r_cap[0]};
    end

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_have    <= '0;
            r_cnt     <= '0;
            r_drop    <= '0;
            r_ovf     <= 1'b0;
            r_timeout <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) r_cap[i] <= '0;
        end else begin
            r_have    <= w_tofire ? 3'b000 : w_have_new;
            r_cnt     <= (r_state == S_COLLECT) ? r_cnt + CW'(1) : '0;
            r_drop    <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            r_timeout <= w_tofire;
            if (w_ovf_drop) r_ovf <= 1'b1;
            for (int unsigned i = 0; i < 3; i++) begin
                if (w_valid[i] && !w_tofire) r_cap[i] <= w_smp[i];
            end
        end
    end

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_fill <= '0;
        end else begin
            r_wr   <= r_wr + AW'(w_push_ok);
            r_rd   <= r_rd + AW'(w_pop);
            r_fill <= r_fill + FW'(w_push_ok) - FW'(w_pop);
        end
    end

    always_ff @(posedge audio_clk) begin
        if (w_push_ok) r_mem[r_wr] <= w_frame;
    end

    assign frame_valid_out = (r_fill != '0);
    assign frame_out       = frame_valid_out ? r_mem[r_rd] : '0;
    assign fill_out        = r_fill;
    assign overflow_out    = r_ovf;
    assign drop_count_out  = r_drop;
    assign timeout_out     = r_timeout;

endmodule

// File: tb/tb_mic_frame_aligner.sv
// Bench for mic_frame_aligner: directed scenarios plus randomized strobes against a frame-level queue model.
module tb_mic_frame_aligner;

    localparam int W = 16;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    vin;
    logic [W-1:0]  s1, s2, s3;
    logic          rdy;

    logic          fv, ovf, tmo;
    logic [3*W-1:0] fo;
    logic [3:0]    fill;
    logic [7:0]    drop;

    logic          t_fv, t_ovf, t_tmo;
    logic [3*W-1:0] t_fo;
    logic [3:0]    t_fill;
    logic [7:0]    t_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mic_frame_aligner #(.WIDTH(W), .DEPTH(D), .TIMEOUT(4096)) u_dut (
        .audio_clk(clk), .rst_in(rst_n), .valid_in(vin),
        .sample_1_in(s1), .sample_2_in(s2), .sample_3_in(s3),
        .frame_ready_in(rdy), .frame_valid_out(fv), .frame_out(fo),
        .fill_out(fill), .overflow_out(ovf), .drop_count_out(drop), .timeout_out(tmo)
    );

    mic_frame_aligner #(.WIDTH(W), .DEPTH(D), .TIMEOUT(16)) u_to (
        .audio_clk(clk), .rst_in(rst_n), .valid_in(vin),
        .sample_1_in(s1), .sample_2_in(s2), .sample_3_in(s3),
        .frame_ready_in(rdy), .frame_valid_out(t_fv), .frame_out(t_fo),
        .fill_out(t_fill), .overflow_out(t_ovf), .drop_count_out(t_drop), .timeout_out(t_tmo)
    );

    task automatic set_in(input logic [2:0] v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        vin = v;
        s1 = v[0] ? a : W'($urandom);
        s2 = v[1] ? b : W'($urandom);
        s3 = v[2] ? c : W'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(3'b000, '0, '0, '0);
        rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy   = 1'b0;
        set_in(3'b000, '0, '0, '0);
        #12;
        checks++; if (fv   !== 1'b0)  begin errors++; $display("FAIL reset_valid got %0b want 0", fv); end
        checks++; if (fo   !== '0)    begin errors++; $display("FAIL reset_frame got %h want 0", fo); end
        checks++; if (fill !== 4'd0)  begin errors++; $display("FAIL reset_fill got %0d want 0", fill); end
        checks++; if (ovf  !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %0b want 0", ovf); end
        checks++; if (drop !== 8'd0)  begin errors++; $display("FAIL reset_drop got %0d want 0", drop); end
        checks++; if (tmo  !== 1'b0)  begin errors++; $display("FAIL reset_timeout got %0b want 0", tmo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_spaced();
        do_reset();
        for (int c = 0; c <= 45; c++) begin
            @(negedge clk);
            case (c)
                10:      set_in(3'b001, 16'h1234, '0, '0);
                25:      set_in(3'b010, '0, 16'h8001, '0);
                40:      set_in(3'b100, '0, '0, 16'h7FFF);
                default: set_in(3'b000, '0, '0, '0);
            endcase
            checks++;
            if (fv !== (c == 42)) begin errors++; $display("FAIL spaced_valid cycle %0d got %0b want %0b", c, fv, c == 42); end
            if (c == 42) begin
                checks++;
                if (fo !== 48'h7FFF_8001_1234) begin errors++; $display("FAIL spaced_frame got %h want 7fff80011234", fo); end
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) set_in(3'b111, 16'h0001, 16'h0002, 16'h0003);
            else        set_in(3'b000, '0, '0, '0);
            checks++;
            if (fv !== (c == 2)) begin errors++; $display("FAIL simul_valid cycle %0d got %0b want %0b", c, fv, c == 2); end
            if (c == 2) begin
                checks++;
                if (fo !== 48'h0003_0002_0001) begin errors++; $display("FAIL simul_frame got %h want 000300020001", fo); end
            end
        end
    endtask

    task automatic test_duplicate();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            case (c)
                0:       set_in(3'b001, 16'h1111, '0, '0);
                2:       set_in(3'b001, 16'h2222, '0, '0);
                4:       set_in(3'b010, '0, 16'hBEEF, '0);
                5:       set_in(3'b100, '0, '0, 16'h0F0F);
                default: set_in(3'b000, '0, '0, '0);
            endcase
            checks++;
            if (fv !== (c == 7)) begin errors++; $display("FAIL dup_valid cycle %0d got %0b want %0b", c, fv, c == 7); end
            if (c == 7) begin
                checks++;
                if (fo !== 48'h0F0F_BEEF_2222) begin errors++; $display("FAIL dup_frame got %h want 0f0fbeef2222", fo); end
            end
        end
        checks++; if (drop !== 8'd1) begin errors++; $display("FAIL dup_drop got %0d want 1", drop); end
        checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL dup_overflow got %0b want 0", ovf); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            if (c == 0) set_in(3'b001, 16'h5555, '0, '0);
            else        set_in(3'b000, '0, '0, '0);
            checks++;
            if (t_tmo !== (c == 16)) begin errors++; $display("FAIL timeout_pulse cycle %0d got %0b want %0b", c, t_tmo, c == 16); end
            checks++;
            if (t_fv !== 1'b0 || tmo !== 1'b0) begin errors++; $display("FAIL timeout_noframe cycle %0d got fv=%0b main_tmo=%0b want 0 0", c, t_fv, tmo); end
        end
        checks++; if (t_drop !== 8'd1) begin errors++; $display("FAIL timeout_drop got %0d want 1", t_drop); end
        checks++; if (drop !== 8'd0)   begin errors++; $display("FAIL timeout_main_drop got %0d want 0", drop); end
    endtask

    task automatic test_back_to_back_overflow();
        logic [W-1:0] n;
        do_reset();
        rdy = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            n = W'(c + 1);
            if (c <= 8) set_in(3'b111, n, n | 16'h0100, n | 16'h0200);
            else        set_in(3'b000, '0, '0, '0);
        end
        checks++; if (fill !== 4'd8) begin errors++; $display("FAIL ovf_fill got %0d want 8", fill); end
        checks++; if (ovf !== 1'b1)  begin errors++; $display("FAIL ovf_flag got %0b want 1", ovf); end
        checks++; if (drop !== 8'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", drop); end
        for (int j = 0; j <= 9; j++) begin
            @(negedge clk);
            rdy = 1'b1;
            n = W'(j + 1);
            checks++;
            if (fill !== 4'(j < 8 ? 8 - j : 0)) begin errors++; $display("FAIL drain_fill step %0d got %0d want %0d", j, fill, j < 8 ? 8 - j : 0); end
            checks++;
            if (fv !== (j < 8)) begin errors++; $display("FAIL drain_valid step %0d got %0b want %0b", j, fv, j < 8); end
            if (j < 8) begin
                checks++;
                if (fo !== {n | 16'h0200, n | 16'h0100, n}) begin
                    errors++; $display("FAIL drain_frame step %0d got %h want %h", j, fo, {n | 16'h0200, n | 16'h0100, n});
                end
            end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", ovf); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] n;
        do_reset();
        rdy = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            n = W'(c + 16'h30);
            if (c <= 2)      set_in(3'b111, n, n, n);
            else if (c == 4) set_in(3'b001, 16'hDEAD, '0, '0);
            else             set_in(3'b000, '0, '0, '0);
        end
        checks++; if (fill !== 4'd3) begin errors++; $display("FAIL areset_prefill got %0d want 3", fill); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fv !== 1'b0)   begin errors++; $display("FAIL areset_valid got %0b want 0", fv); end
        checks++; if (fo !== '0)     begin errors++; $display("FAIL areset_frame got %h want 0", fo); end
        checks++; if (fill !== 4'd0) begin errors++; $display("FAIL areset_fill got %0d want 0", fill); end
        checks++; if (drop !== 8'd0 || ovf !== 1'b0 || tmo !== 1'b0) begin
            errors++; $display("FAIL areset_flags got drop=%0d ovf=%0b tmo=%0b want 0 0 0", drop, ovf, tmo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rdy   = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (c == 4)      set_in(3'b110, '0, 16'h00A2, 16'h00A3);
            else if (c == 5) set_in(3'b001, 16'h00A1, '0, '0);
            else             set_in(3'b000, '0, '0, '0);
            checks++;
            if (fv !== (c == 7)) begin errors++; $display("FAIL areset_after_valid cycle %0d got %0b want %0b", c, fv, c == 7); end
            if (c == 7) begin
                checks++;
                if (fo !== 48'h00A3_00A2_00A1) begin errors++; $display("FAIL areset_after_frame got %h want 00a300a200a1", fo); end
            end
        end
    endtask

    task automatic test_random();
        logic [3*W-1:0] exp_q[$];
        logic [W-1:0]   cap [3];
        logic [W-1:0]   smp [3];
        bit   [2:0]     have;
        logic [2:0]     v;
        int             exp_drop;
        logic [3*W-1:0] want;
        do_reset();
        have = '0;
        exp_drop = 0;
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < (phase == 0 ? 500 : 2000); n++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    v[i]   = ($urandom_range(0, 4) == 0);
                    smp[i] = W'($urandom);
                end
                rdy = ($urandom_range(0, 3) != 0);
                set_in(v, smp[0], smp[1], smp[2]);
                for (int i = 0; i < 3; i++) begin
                    if (v[i]) begin
                        if (have[i]) exp_drop++;
                        have[i] = 1'b1;
                        cap[i]  = smp[i];
                    end
                end
                if (have == 3'b111) begin
                    exp_q.push_back({cap[2], cap[1], cap[0]});
                    have = '0;
                end
                if (fv && rdy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL rand_pop unexpected frame %h want none", fo);
                    end else begin
                        want = exp_q.pop_front();
                        if (fo !== want) begin errors++; $display("FAIL rand_frame got %h want %h", fo, want); end
                    end
                end
            end
            @(negedge clk);
            set_in(3'b000, '0, '0, '0);
            rdy = 1'b0;
            @(negedge clk);
            checks++;
            if (drop !== 8'(exp_drop > 255 ? 255 : exp_drop)) begin
                errors++; $display("FAIL rand_drop phase %0d got %0d want %0d", phase, drop, exp_drop > 255 ? 255 : exp_drop);
            end
        end
        rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (fv) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_drain unexpected frame %h want none", fo);
                end else begin
                    want = exp_q.pop_front();
                    if (fo !== want) begin errors++; $display("FAIL rand_drain_frame got %h want %h", fo, want); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d frames missing want 0", exp_q.size()); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rand_overflow got %0b want 0", ovf); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_spaced();
        test_simultaneous();
        test_duplicate();
        test_timeout();
        test_back_to_back_overflow();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
